ysyx_25040111_wbu: RTL and testbench

YSYX_25040111_WBU -- requirements
Module: ysyx_25040111_wbu

---
 rtl/ysyx_25040111_wbu.sv | 94 +++++++++
 tb/tb_ysyx_25040111_wbu.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25040111_wbu.sv
// Write-back unit: arbitrates EXU/LSU results into one registered register-file write port
// and keeps a pending-write scoreboard for the issue stage.
module ysyx_25040111_wbu (
    input  logic        clock,
    input  logic        reset,
    input  logic        exu_valid,
    output logic        exu_ready,
    input  logic        exu_wen,
    input  logic [3:0]  exu_rd,
    input  logic [31:0] exu_data,
    input  logic        lsu_valid,
    output logic        lsu_ready,
    input  logic [3:0]  lsu_rd,
    input  logic [31:0] lsu_data,
    input  logic        iss_valid,
    input  logic [3:0]  iss_rd,
    output logic        wen,
    output logic [3:0]  waddr,
    output logic [31:0] wdata,
    output logic        commit,
    output logic [15:0] busy
);

    logic        last_lsu;
    logic        exu_acc;
    logic        lsu_acc;
    logic        acc;
    logic        acc_real;
    logic [3:0]  acc_rd;
    logic [31:0] acc_data;
    logic [15:0] busy_q;
    logic [15:0] busy_d;

    // Ready depends only on the valids and the round-robin flop; a source is
    // refused only when the other side wins a two-way conflict.
    assign lsu_ready = reset & ~(exu_valid & last_lsu);
    assign exu_ready = reset & ~(lsu_valid & ~last_lsu);

    assign exu_acc = exu_valid & exu_ready;
    assign lsu_acc = lsu_valid & lsu_ready;
    assign acc     = exu_acc | lsu_acc;

    always_comb begin
        acc_rd   = 4'd0;
        acc_data = 32'd0;
        acc_real = 1'b0;
        if (lsu_acc) begin
            acc_rd   = lsu_rd;
            acc_data = lsu_data;
            acc_real = 1'b1;
        end else if (exu_acc) begin
            acc_rd   = exu_rd;
            acc_data = exu_data;
            acc_real = exu_wen;
        end
    end

    // Clear first so a same-cycle issue to the same index keeps the bit set.
    always_comb begin
        busy_d = busy_q;
        if (acc && acc_rd != 4'd0) begin
            busy_d[acc_rd] = 1'b0;
        end
        if (iss_valid && iss_rd != 4'd0) begin
            busy_d[iss_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_lsu <= 1'b0;
            wen      <= 1'b0;
            commit   <= 1'b0;
            waddr    <= 4'd0;
            wdata    <= 32'd0;
            busy_q   <= 16'd0;
        end else begin
            if (exu_valid && lsu_valid) begin
                last_lsu <= lsu_acc;
            end
            commit <= acc;
            wen    <= acc & acc_real & (acc_rd != 4'd0);
            if (acc) begin
                waddr <= acc_rd;
                wdata <= acc_data;
            end
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

endmodule

// File: tb/tb_ysyx_25040111_wbu.sv
// Bench for ysyx_25040111_wbu: directed vector table, randomized traffic against a
// transaction-level model, and a mid-operation reset sequence.
module tb_ysyx_25040111_wbu;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        exu_valid = 1'b0, exu_wen = 1'b0, lsu_valid = 1'b0, iss_valid = 1'b0;
    logic [3:0]  exu_rd = 4'd0, lsu_rd = 4'd0, iss_rd = 4'd0;
    logic [31:0] exu_data = 32'd0, lsu_data = 32'd0;
    logic        exu_ready, lsu_ready, wen, commit;
    logic [3:0]  waddr;
    logic [31:0] wdata;
    logic [15:0] busy;

    ysyx_25040111_wbu dut (
        .clock(clock), .reset(reset),
        .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_wen(exu_wen),
        .exu_rd(exu_rd), .exu_data(exu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .wen(wen), .waddr(waddr), .wdata(wdata), .commit(commit), .busy(busy)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        ev;
        logic        ew;
        logic [3:0]  erd;
        logic [31:0] ed;
        logic        lv;
        logic [3:0]  lrd;
        logic [31:0] ld;
        logic        iv;
        logic [3:0]  ird;
    } in_t;

    typedef struct {
        in_t         in;
        logic        x_commit;
        logic        x_wen;
        logic [3:0]  x_waddr;
        logic [31:0] x_wdata;
        logic [15:0] x_busy;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    // Transaction-level model: who won the last conflict, last write seen, pending set.
    logic        m_lsu_won;
    logic        m_commit, m_wen;
    logic [3:0]  m_waddr;
    logic [31:0] m_wdata;
    logic [15:0] m_busy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_lsu_won = 1'b0;
        m_commit  = 1'b0;
        m_wen     = 1'b0;
        m_waddr   = 4'd0;
        m_wdata   = 32'd0;
        m_busy    = 16'd0;
    endtask

    task automatic drive(input in_t s);
        exu_valid = s.ev; exu_wen = s.ew; exu_rd = s.erd; exu_data = s.ed;
        lsu_valid = s.lv; lsu_rd = s.lrd; lsu_data = s.ld;
        iss_valid = s.iv; iss_rd = s.ird;
    endtask

    task automatic step(input in_t s, output logic ae, output logic al);
        logic ge, gl;
        logic [3:0] rd;
        @(negedge clock);
        drive(s);
        #1;
        gl = s.lv && (!s.ev || !m_lsu_won);
        ge = s.ev && !gl;
        if (s.ev) chk("exu_ready", {31'd0, exu_ready}, {31'd0, ge});
        if (s.lv) chk("lsu_ready", {31'd0, lsu_ready}, {31'd0, gl});
        if (s.ev || s.lv)
            chk("no_bubble", {31'd0, (exu_valid & exu_ready) | (lsu_valid & lsu_ready)}, 32'd1);
        @(posedge clock);
        if (s.ev && s.lv) m_lsu_won = gl;
        m_commit = ge || gl;
        rd = gl ? s.lrd : s.erd;
        if (m_commit) begin
            m_waddr = rd;
            m_wdata = gl ? s.ld : s.ed;
            m_wen   = (rd != 4'd0) && (gl || s.ew);
            if (rd != 4'd0) m_busy[rd] = 1'b0;
        end else begin
            m_wen = 1'b0;
        end
        if (s.iv && s.ird != 4'd0) m_busy[s.ird] = 1'b1;
        #1;
        chk("commit", {31'd0, commit}, {31'd0, m_commit});
        chk("wen", {31'd0, wen}, {31'd0, m_wen});
        chk("waddr", {28'd0, waddr}, {28'd0, m_waddr});
        chk("wdata", wdata, m_wdata);
        chk("busy", {16'd0, busy}, {16'd0, m_busy});
        ae = ge;
        al = gl;
    endtask

    vec_t tbl[12];
    in_t  idle;
    in_t  s;
    logic ae, al;

    initial begin
        idle = '0;
        //            ev    ew    erd   ed            lv    lrd   ld            iv    ird
        tbl[0]  = '{'{1'b1, 1'b1, 4'd5, 32'h1234,     1'b0, 4'd0, 32'h0,        1'b0, 4'd0},
                    1'b1, 1'b1, 4'd5, 32'h1234, 16'h0000};
        tbl[1]  = '{idle, 1'b0, 1'b0, 4'd5, 32'h1234, 16'h0000};
        tbl[2]  = '{'{1'b1, 1'b1, 4'd1, 32'hAAAA,     1'b1, 4'd2, 32'hBBBB,     1'b0, 4'd0},
                    1'b1, 1'b1, 4'd2, 32'hBBBB, 16'h0000};
        tbl[3]  = '{'{1'b1, 1'b1, 4'd1, 32'hAAAA,     1'b1, 4'd4, 32'hCCCC,     1'b0, 4'd0},
                    1'b1, 1'b1, 4'd1, 32'hAAAA, 16'h0000};
        tbl[4]  = '{'{1'b0, 1'b0, 4'd0, 32'h0,        1'b1, 4'd4, 32'hCCCC,     1'b0, 4'd0},
                    1'b1, 1'b1, 4'd4, 32'hCCCC, 16'h0000};
        tbl[5]  = '{'{1'b1, 1'b1, 4'd0, 32'h55,       1'b0, 4'd0, 32'h0,        1'b0, 4'd0},
                    1'b1, 1'b0, 4'd0, 32'h55, 16'h0000};
        tbl[6]  = '{'{1'b1, 1'b0, 4'd3, 32'h66,       1'b0, 4'd0, 32'h0,        1'b0, 4'd0},
                    1'b1, 1'b0, 4'd3, 32'h66, 16'h0000};
        tbl[7]  = '{idle, 1'b0, 1'b0, 4'd3, 32'h66, 16'h0000};
        tbl[8]  = '{'{1'b0, 1'b0, 4'd0, 32'h0,        1'b0, 4'd0, 32'h0,        1'b1, 4'd7},
                    1'b0, 1'b0, 4'd3, 32'h66, 16'h0080};
        tbl[9]  = '{'{1'b0, 1'b0, 4'd0, 32'h0,        1'b1, 4'd7, 32'h77,       1'b1, 4'd7},
                    1'b1, 1'b1, 4'd7, 32'h77, 16'h0080};
        tbl[10] = '{'{1'b0, 1'b0, 4'd0, 32'h0,        1'b1, 4'd7, 32'h78,       1'b0, 4'd0},
                    1'b1, 1'b1, 4'd7, 32'h78, 16'h0000};
        tbl[11] = '{'{1'b0, 1'b0, 4'd0, 32'h0,        1'b0, 4'd0, 32'h0,        1'b1, 4'd0},
                    1'b0, 1'b0, 4'd7, 32'h78, 16'h0000};

        // Held in reset with both sources offering: nothing may be accepted.
        model_reset();
        drive('{1'b1, 1'b1, 4'd5, 32'h1, 1'b1, 4'd6, 32'h2, 1'b1, 4'd8});
        #12;
        chk("rst_exu_ready", {31'd0, exu_ready}, 32'd0);
        chk("rst_lsu_ready", {31'd0, lsu_ready}, 32'd0);
        chk("rst_commit", {31'd0, commit}, 32'd0);
        chk("rst_busy", {16'd0, busy}, 32'd0);
        drive(idle);
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < 12; i++) begin
            step(tbl[i].in, ae, al);
            chk($sformatf("vec%0d_commit", i), {31'd0, commit}, {31'd0, tbl[i].x_commit});
            chk($sformatf("vec%0d_wen", i), {31'd0, wen}, {31'd0, tbl[i].x_wen});
            chk($sformatf("vec%0d_waddr", i), {28'd0, waddr}, {28'd0, tbl[i].x_waddr});
            chk($sformatf("vec%0d_wdata", i), wdata, tbl[i].x_wdata);
            chk($sformatf("vec%0d_busy", i), {16'd0, busy}, {16'd0, tbl[i].x_busy});
        end

        // Random traffic; a refused source keeps its valid and payload stable.
        s = idle;
        for (int i = 0; i < 400; i++) begin
            if (!s.ev) begin
                s.ev  = ($urandom_range(0, 99) < 60);
                s.ew  = ($urandom_range(0, 3) != 0);
                s.erd = 4'($urandom_range(0, 15));
                s.ed  = $urandom;
            end
            if (!s.lv) begin
                s.lv  = ($urandom_range(0, 99) < 50);
                s.lrd = 4'($urandom_range(0, 15));
                s.ld  = $urandom;
            end
            s.iv  = ($urandom_range(0, 99) < 40);
            s.ird = 4'($urandom_range(0, 15));
            step(s, ae, al);
            if (ae) s.ev = 1'b0;
            if (al) s.lv = 1'b0;
        end
        step(idle, ae, al);

        // Mid-operation reset: result being accepted while the scoreboard is non-zero.
        step('{1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b1, 4'd9}, ae, al);
        chk("pre_rst_busy9", {31'd0, busy[9]}, 32'd1);
        @(negedge clock);
        drive('{1'b1, 1'b1, 4'd10, 32'hDEAD, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0});
        #1;
        chk("pre_rst_accept", {31'd0, exu_ready}, 32'd1);
        #1;
        reset = 1'b0;
        #1;
        chk("mid_rst_wen", {31'd0, wen}, 32'd0);
        chk("mid_rst_commit", {31'd0, commit}, 32'd0);
        chk("mid_rst_waddr", {28'd0, waddr}, 32'd0);
        chk("mid_rst_wdata", wdata, 32'd0);
        chk("mid_rst_busy", {16'd0, busy}, 32'd0);
        chk("mid_rst_exu_ready", {31'd0, exu_ready}, 32'd0);
        chk("mid_rst_lsu_ready", {31'd0, lsu_ready}, 32'd0);
        @(posedge clock);
        #1;
        chk("post_rst_no_commit", {31'd0, commit}, 32'd0);
        @(negedge clock);
        drive(idle);
        reset = 1'b1;
        model_reset();
        // First edge after release accepts; the round-robin state is back to LSU-first.
        step('{1'b1, 1'b1, 4'd6, 32'h600D, 1'b1, 4'd11, 32'hB00B, 1'b0, 4'd0}, ae, al);
        chk("post_rst_lsu_first", {31'd0, al}, 32'd1);
        step('{1'b1, 1'b1, 4'd6, 32'h600D, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0}, ae, al);
        step(idle, ae, al);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish (got running, want done)");
        $fatal(1);
    end

endmodule
